timer_bank: RTL

Parametrised multi-channel countdown timer for the clock design. It replaces the single fixed-width timer with N_CH independent channels. Each channel has load/start/pause/cancel control, optional auto-repeat, a latched buzzer with acknowledge and timeout, and a min/sec readout port. The block sits beside the timekeeper and is advanced by the shared 1 Hz `tick` strobe rather than by every `clk` edge.

---
 rtl/timer_bank.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/timer_bank.sv
// -----------------------------------------------------------------------------
// timer_bank
//   Multi-channel countdown timer advanced by a shared 1 Hz tick strobe.
//   Each channel supports LOAD / START / PAUSE / CANCEL / ACK commands,
//   optional auto-repeat, and a latched buzzer with an optional tick timeout.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high; clears all state
//   tick       in   one-clk-wide 1 Hz strobe
//   cmd_valid  in   command strobe, sampled each posedge
//   cmd_ch     in   target channel of the command
//   cmd_op     in   0 NOP, 1 LOAD, 2 START, 3 PAUSE, 4 CANCEL, 5 ACK
//   cmd_value  in   LOAD value in seconds
//   cmd_repeat in   LOAD only: channel auto-reloads on expiry
//   rd_ch      in   readout channel select
//   rd_min     out  remaining whole minutes of rd_ch (combinational)
//   rd_sec     out  remaining seconds of rd_ch (combinational)
//   ch_state   out  per-channel state, channel i at [3i+2:3i]
//   buzzer     out  per-channel latched buzzer
//   any_buzz   out  OR of all buzzers
//   cmd_err    out  one-cycle pulse the cycle after an illegal command
// -----------------------------------------------------------------------------
module timer_bank #(
  parameter int N_CH       = 4,
  parameter int SEC_W      = 12,
  parameter int BUZZ_TICKS = 10,
  parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                cmd_valid,
  input  logic [CH_W-1:0]     cmd_ch,
  input  logic [2:0]          cmd_op,
  input  logic [SEC_W-1:0]    cmd_value,
  input  logic                cmd_repeat,
  input  logic [CH_W-1:0]     rd_ch,
  output logic [SEC_W-1:0]    rd_min,
  output logic [5:0]          rd_sec,
  output logic [3*N_CH-1:0]   ch_state,
  output logic [N_CH-1:0]     buzzer,
  output logic                any_buzz,
  output logic                cmd_err
);

  localparam int BW = (BUZZ_TICKS > 0) ? $clog2(BUZZ_TICKS + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOADED  = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_EXPIRED = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_START  = 3'd2,
    OP_PAUSE  = 3'd3,
    OP_CANCEL = 3'd4,
    OP_ACK    = 3'd5,
    OP_BAD6   = 3'd6,
    OP_BAD7   = 3'd7
  } op_t;

  // Per-channel registers and their next values
  state_t           st_q   [N_CH];
  state_t           st_d   [N_CH];
  logic [SEC_W-1:0] cnt_q  [N_CH];
  logic [SEC_W-1:0] cnt_d  [N_CH];
  logic [SEC_W-1:0] rld_q  [N_CH];
  logic [SEC_W-1:0] rld_d  [N_CH];
  logic             rep_q  [N_CH];
  logic             rep_d  [N_CH];
  logic             buz_q  [N_CH];
  logic             buz_d  [N_CH];
  logic [BW-1:0]    bcnt_q [N_CH];
  logic [BW-1:0]    bcnt_d [N_CH];

  op_t    op;
  state_t sel_st;
  logic   sel_buz;
  logic   ch_ok;
  logic   op_ok;
  logic   cmd_legal;
  logic   cmd_illegal;

  assign op = op_t'(cmd_op);

  // ---------------------------------------------------------------------------
  // Command legality: look up the addressed channel, then check the op against
  // that channel's state. An out-of-range cmd_ch matches no channel.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    sel_st  = ST_IDLE;
    sel_buz = 1'b0;
    ch_ok   = 1'b0;
    op_ok   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (cmd_ch == CH_W'(i)) begin
        ch_ok   = 1'b1;
        sel_st  = st_q[i];
        sel_buz = buz_q[i];
      end
    end
    case (op)
      OP_NOP:    op_ok = 1'b1;
      OP_LOAD:   op_ok = ((sel_st == ST_IDLE) || (sel_st == ST_LOADED)) &&
                         (cmd_value != '0);
      OP_START:  op_ok = (sel_st == ST_LOADED) || (sel_st == ST_PAUSED);
      OP_PAUSE:  op_ok = (sel_st == ST_RUN);
      OP_CANCEL: op_ok = 1'b1;
      OP_ACK:    op_ok = sel_buz;
      default:   op_ok = 1'b0;
    endcase
    cmd_legal   = cmd_valid && (op != OP_NOP) && ch_ok && op_ok;
    cmd_illegal = cmd_valid && (op != OP_NOP) && !(ch_ok && op_ok);
  end

  // ---------------------------------------------------------------------------
  // Per-channel next state. A legal command on a channel takes precedence over
  // that channel's tick in the same cycle; the tick is simply dropped there.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      st_d[i]   = st_q[i];
      cnt_d[i]  = cnt_q[i];
      rld_d[i]  = rld_q[i];
      rep_d[i]  = rep_q[i];
      buz_d[i]  = buz_q[i];
      bcnt_d[i] = bcnt_q[i];

      if (cmd_legal && (cmd_ch == CH_W'(i))) begin
        case (op)
          OP_LOAD: begin
            cnt_d[i] = cmd_value;
            rld_d[i] = cmd_value;
            rep_d[i] = cmd_repeat;
            st_d[i]  = ST_LOADED;
          end
          OP_START: st_d[i] = ST_RUN;
          OP_PAUSE: st_d[i] = ST_PAUSED;
          OP_CANCEL: begin
            st_d[i]   = ST_IDLE;
            cnt_d[i]  = '0;
            rep_d[i]  = 1'b0;
            buz_d[i]  = 1'b0;
            bcnt_d[i] = '0;
          end
          OP_ACK: begin
            buz_d[i]  = 1'b0;
            bcnt_d[i] = '0;
            if (st_q[i] == ST_EXPIRED) st_d[i] = ST_IDLE;
          end
          default: ;
        endcase
      end else if (tick) begin
        // Buzzer timeout runs first; an expiry on the same tick overrides it
        // below so a repeating channel re-arms rather than going quiet.
        if ((BUZZ_TICKS != 0) && buz_q[i]) begin
          if (bcnt_q[i] + BW'(1) == BW'(BUZZ_TICKS)) begin
            buz_d[i]  = 1'b0;
            bcnt_d[i] = '0;
            if (st_q[i] == ST_EXPIRED) st_d[i] = ST_IDLE;
          end else begin
            bcnt_d[i] = bcnt_q[i] + BW'(1);
          end
        end
        if (st_q[i] == ST_RUN) begin
          if (cnt_q[i] > SEC_W'(1)) begin
            cnt_d[i] = cnt_q[i] - SEC_W'(1);
          end else begin
            buz_d[i]  = 1'b1;
            bcnt_d[i] = '0;
            if (rep_q[i]) begin
              cnt_d[i] = rld_q[i];
            end else begin
              cnt_d[i] = '0;
              st_d[i]  = ST_EXPIRED;
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the per-channel arrays are real control state, not bulk storage,
      // so every element is explicitly cleared on reset.
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]   <= ST_IDLE;
        cnt_q[i]  <= '0;
        rld_q[i]  <= '0;
        rep_q[i]  <= 1'b0;
        buz_q[i]  <= 1'b0;
        bcnt_q[i] <= '0;
      end
      cmd_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]   <= st_d[i];
        cnt_q[i]  <= cnt_d[i];
        rld_q[i]  <= rld_d[i];
        rep_q[i]  <= rep_d[i];
        buz_q[i]  <= buz_d[i];
        bcnt_q[i] <= bcnt_d[i];
      end
      cmd_err <= cmd_illegal;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [SEC_W-1:0] rd_count;

  always_comb begin
    rd_count = '0;
    ch_state = '0;
    buzzer   = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_state[3*i +: 3] = st_q[i];
      buzzer[i]          = buz_q[i];
      if (rd_ch == CH_W'(i)) rd_count = cnt_q[i];
    end
  end

  // Division by a constant 60 synthesises to fixed logic on the selected count.
  assign rd_min   = SEC_W'(rd_count / SEC_W'(60));
  assign rd_sec   = 6'(rd_count % SEC_W'(60));
  assign any_buzz = |buzzer;

endmodule
